// File: rtl/pixel_stream_fifo.sv
// Single-clock pixel buffer between the pattern source and the VGA output.
// Registered read port with one cycle of latency; empty reads return BLANK.
module pixel_stream_fifo #(
    parameter int                 NCH       = 3,
    parameter int                 BPC       = 8,
    parameter int                 DEPTH     = 16,
    parameter int                 AF_THRESH = 12,
    parameter logic [NCH*BPC-1:0] BLANK     = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      wr_en,
    input  logic [NCH*BPC-1:0]        din,
    output logic                      full,
    output logic                      almost_full,
    input  logic                      rd_en,
    output logic [NCH*BPC-1:0]        dout,
    output logic                      dout_valid,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      overflow,
    output logic                      underflow,
    output logic [15:0]               ufl_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_LVL   = (AW+1)'(AF_THRESH);

    typedef logic [NCH-1:0][BPC-1:0] pix_t;

    pix_t          mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic          wr_acc, rd_acc;

    assign full        = (level == FULL_LVL);
    assign empty       = (level == '0);
    assign almost_full = (level >= AF_LVL);

    // Flush blocks both ports so a flush cycle never moves data.
    assign wr_acc = wr_en & ~full  & ~flush;
    assign rd_acc = rd_en & ~empty & ~flush;

    // Storage carries no reset; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wptr] <= pix_t'(din);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr       <= '0;
            rptr       <= '0;
            level      <= '0;
            dout       <= BLANK;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            ufl_cnt    <= '0;
        end else if (flush) begin
            wptr       <= '0;
            rptr       <= '0;
            level      <= '0;
            dout       <= BLANK;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            ufl_cnt    <= '0;
        end else begin
            if (wr_acc) wptr <= wptr + AW'(1);
            if (rd_acc) begin
                rptr       <= rptr + AW'(1);
                dout       <= mem[rptr];
                dout_valid <= 1'b1;
            end else begin
                dout_valid <= 1'b0;
                if (rd_en) dout <= BLANK;
            end
            // Same-cycle write at empty is not bypassed: the read still underflows.
            if (rd_en && empty) begin
                underflow <= 1'b1;
                if (ufl_cnt != 16'hFFFF) ufl_cnt <= ufl_cnt + 16'd1;
            end
            if (wr_en && full) overflow <= 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end
endmodule
